// File: rtl/parking_pkg.sv
// Shared types for the parking access controller: gate states, arbiter grants, occupancy width.
package parking_pkg;

  localparam int OCC_W = 7;

  typedef enum logic [1:0] {
    G_CLOSED,
    G_OPEN,
    G_PASS
  } gate_state_t;

  typedef enum logic [1:0] {
    GR_NONE,
    GR_IN,
    GR_OUT
  } grant_t;

endpackage

// File: rtl/pending_counter.sv
// Saturating count of requests awaiting arbitration; a request and a take on the same edge cancel.
// sat_err flags a request that arrives while the count is already at its maximum.
module pending_counter #(
  parameter int PEND_W = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req,
  input  logic take,
  output logic nonzero,
  output logic sat_err
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] cnt;

  // take is only ever asserted while nonzero, so the count cannot wrap below zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (req && !take) begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else if (!req && take) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign nonzero = |cnt;
  assign sat_err = req && !take && (cnt == CNT_MAX);

endmodule

// File: rtl/parking_access_ctrl.sv
// Merges entry/exit pulses into one inc/dec strobe per cycle (2 edges request-to-strobe) and mirrors occupancy.
// Entry barrier FSM is compiled in only when PARKING_GATE_EN is defined; otherwise gate_open is tied low.
module parking_access_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY     = 99,
  parameter int PEND_W       = 3,
  parameter int GATE_TIMEOUT = 500_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ent_req,
  input  logic             ext_req,
  input  logic             arrive,
  output logic             inc,
  output logic             dec,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             gate_open,
  output logic             err
);

  localparam logic [OCC_W-1:0] CAP = OCC_W'(CAPACITY);

  grant_t           grant;
  grant_t           rr_last;
  logic             in_nz;
  logic             out_nz;
  logic             in_sat;
  logic             out_sat;
  logic             take_in;
  logic             take_out;
  logic [OCC_W-1:0] occ_nxt;

  pending_counter #(.PEND_W(PEND_W)) u_pend_in (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (ent_req),
    .take    (take_in),
    .nonzero (in_nz),
    .sat_err (in_sat)
  );

  pending_counter #(.PEND_W(PEND_W)) u_pend_out (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (ext_req),
    .take    (take_out),
    .nonzero (out_nz),
    .sat_err (out_sat)
  );

  // rr_last only moves on contention, so uncontended traffic never shifts the tie-break
  always_comb begin
    grant = GR_NONE;
    if (in_nz && out_nz) grant = (rr_last == GR_IN) ? GR_OUT : GR_IN;
    else if (in_nz)      grant = GR_IN;
    else if (out_nz)     grant = GR_OUT;
  end

  assign take_in  = (grant == GR_IN);
  assign take_out = (grant == GR_OUT);

  always_comb begin
    occ_nxt = occupancy;
    if (take_in && !full)       occ_nxt = occupancy + 1'b1;
    else if (take_out && !empty) occ_nxt = occupancy - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      inc       <= 1'b0;
      dec       <= 1'b0;
      occupancy <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      err       <= 1'b0;
      rr_last   <= GR_OUT;
    end else begin
      inc       <= take_in && !full;
      dec       <= take_out && !empty;
      occupancy <= occ_nxt;
      full      <= (occ_nxt == CAP);
      empty     <= (occ_nxt == '0);
      if (in_nz && out_nz) rr_last <= grant;
      // a granted event that cannot be applied is discarded and flagged
      if (in_sat || out_sat || (take_in && full) || (take_out && empty)) err <= 1'b1;
    end
  end

`ifdef PARKING_GATE_EN
  localparam int TO_W = (GATE_TIMEOUT > 2) ? $clog2(GATE_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(GATE_TIMEOUT - 1);

  gate_state_t     g_state;
  gate_state_t     g_nxt;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      g_state   <= G_CLOSED;
      to_cnt    <= '0;
      gate_open <= 1'b0;
    end else begin
      g_state   <= g_nxt;
      gate_open <= (g_nxt != G_CLOSED);
      to_cnt    <= (g_state == G_OPEN && g_nxt == G_OPEN) ? to_cnt + 1'b1 : '0;
    end
  end

  // a lot that fills while the barrier is up leaves it up; only timeout or entry moves on
  always_comb begin
    g_nxt = g_state;
    case (g_state)
      G_CLOSED: if (arrive && !full) g_nxt = G_OPEN;
      G_OPEN: begin
        if (ent_req)                g_nxt = G_PASS;
        else if (to_cnt == TO_LAST) g_nxt = G_CLOSED;
      end
      G_PASS:   if (!arrive) g_nxt = G_CLOSED;
      default:  g_nxt = G_CLOSED;
    endcase
  end
`else
  logic unused_arrive;
  assign unused_arrive = arrive;
  assign gate_open     = 1'b0;
`endif

endmodule

// File: tb/tb_parking_access_ctrl.sv
// Directed bench: a 99-slot/PEND_W=3 instance and a 3-slot/PEND_W=2 instance share one stimulus stream.
module tb_parking_access_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ent_req = 1'b0;
  logic       ext_req = 1'b0;
  logic       arrive = 1'b0;

  logic       b_inc, b_dec, b_full, b_empty, b_gate, b_err;
  logic [6:0] b_occ;
  logic       s_inc, s_dec, s_full, s_empty, s_gate, s_err;
  logic [6:0] s_occ;

  int pass_cnt = 0;
  int total_cnt = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  parking_access_ctrl #(.CAPACITY(99), .PEND_W(3), .GATE_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .ent_req(ent_req), .ext_req(ext_req), .arrive(arrive),
    .inc(b_inc), .dec(b_dec), .occupancy(b_occ), .full(b_full), .empty(b_empty),
    .gate_open(b_gate), .err(b_err)
  );

  parking_access_ctrl #(.CAPACITY(3), .PEND_W(2), .GATE_TIMEOUT(16)) dut_s (
    .clk(clk), .reset_n(reset_n), .ent_req(ent_req), .ext_req(ext_req), .arrive(arrive),
    .inc(s_inc), .dec(s_dec), .occupancy(s_occ), .full(s_full), .empty(s_empty),
    .gate_open(s_gate), .err(s_err)
  );

  always @(negedge clk) begin
    if (b_inc && b_dec) overlap++;
    if (s_inc && s_dec) overlap++;
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; ent_req = 1'b0; ext_req = 1'b0; arrive = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({b_inc, b_dec, b_occ, b_full, b_empty, b_gate, b_err} !== 13'b0_0_0000000_0_1_0_0)
      $display("FAIL reset_big: got %b want %b", {b_inc, b_dec, b_occ, b_full, b_empty, b_gate, b_err}, 13'b0_0_0000000_0_1_0_0);
    else pass_cnt++;
    total_cnt++;
    if ({s_inc, s_dec, s_occ, s_full, s_empty, s_gate, s_err} !== 13'b0_0_0000000_0_1_0_0)
      $display("FAIL reset_small: got %b want %b", {s_inc, s_dec, s_occ, s_full, s_empty, s_gate, s_err}, 13'b0_0_0000000_0_1_0_0);
    else pass_cnt++;
    reset_n = 1'b1;
  endtask

  task automatic test_single_entry();
    do_reset();
    @(negedge clk); ent_req = 1'b1;
    @(negedge clk); ent_req = 1'b0;
    total_cnt++;
    if ({b_inc, b_occ, b_empty} !== {1'b0, 7'd0, 1'b1})
      $display("FAIL single_edge1: got %b want %b", {b_inc, b_occ, b_empty}, {1'b0, 7'd0, 1'b1});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({b_inc, b_occ, b_empty} !== {1'b1, 7'd1, 1'b0})
      $display("FAIL single_edge2: got %b want %b", {b_inc, b_occ, b_empty}, {1'b1, 7'd1, 1'b0});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({b_inc, b_occ, b_empty} !== {1'b0, 7'd1, 1'b0})
      $display("FAIL single_edge3: got %b want %b", {b_inc, b_occ, b_empty}, {1'b0, 7'd1, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] hist;
    hist = '0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      hist[i] = b_inc;
      ent_req = (i < 5);
    end
    total_cnt++;
    if (hist !== 12'b0000_0111_1100)
      $display("FAIL b2b_inc_run: got %b want %b", hist, 12'b0000_0111_1100);
    else pass_cnt++;
    total_cnt++;
    if (b_occ !== 7'd5) $display("FAIL b2b_occ: got %0d want 5", b_occ);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    @(negedge clk); ent_req = 1'b1; ext_req = 1'b1;
    @(negedge clk); ent_req = 1'b0; ext_req = 1'b0;
    total_cnt++;
    if ({b_inc, b_dec, b_occ} !== {1'b0, 1'b0, 7'd5})
      $display("FAIL simul_edge1: got %b want %b", {b_inc, b_dec, b_occ}, {1'b0, 1'b0, 7'd5});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({b_inc, b_dec, b_occ} !== {1'b1, 1'b0, 7'd6})
      $display("FAIL simul_inc_first: got %b want %b", {b_inc, b_dec, b_occ}, {1'b1, 1'b0, 7'd6});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({b_inc, b_dec, b_occ} !== {1'b0, 1'b1, 7'd5})
      $display("FAIL simul_dec_second: got %b want %b", {b_inc, b_dec, b_occ}, {1'b0, 1'b1, 7'd5});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({b_inc, b_dec, b_occ} !== {1'b0, 1'b0, 7'd5})
      $display("FAIL simul_idle: got %b want %b", {b_inc, b_dec, b_occ}, {1'b0, 1'b0, 7'd5});
    else pass_cnt++;
  endtask

  task automatic test_capacity();
    int s_incs;
    s_incs = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_inc) s_incs++;
      ent_req = (i < 4);
    end
    total_cnt++;
    if (s_incs !== 3) $display("FAIL cap_inc_count: got %0d want 3", s_incs);
    else pass_cnt++;
    total_cnt++;
    if ({s_occ, s_full, s_err} !== {7'd3, 1'b1, 1'b1})
      $display("FAIL cap_full_err: got %b want %b", {s_occ, s_full, s_err}, {7'd3, 1'b1, 1'b1});
    else pass_cnt++;
    total_cnt++;
    if ({b_occ, b_full, b_err} !== {7'd4, 1'b0, 1'b0})
      $display("FAIL cap_big_unaffected: got %b want %b", {b_occ, b_full, b_err}, {7'd4, 1'b0, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_gate_full();
`ifdef PARKING_GATE_EN
    logic seen;
    seen = 1'b0;
    arrive = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen |= s_gate;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL gate_full_closed: got %b want 0", seen);
    else pass_cnt++;
    ext_req = 1'b1;
    @(negedge clk); ext_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({s_full, s_gate} !== 2'b00)
      $display("FAIL gate_full_drop: got %b want 00", {s_full, s_gate});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (s_gate !== 1'b1) $display("FAIL gate_after_full: got %b want 1", s_gate);
    else pass_cnt++;
    arrive = 1'b0;
`endif
  endtask

  task automatic test_underflow();
    logic dec_seen;
    dec_seen = 1'b0;
    do_reset();
    @(negedge clk); ext_req = 1'b1;
    @(negedge clk); ext_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dec_seen |= b_dec | s_dec;
    end
    total_cnt++;
    if (dec_seen !== 1'b0) $display("FAIL underflow_no_dec: got %b want 0", dec_seen);
    else pass_cnt++;
    total_cnt++;
    if ({b_err, s_err, b_occ, b_empty} !== {1'b1, 1'b1, 7'd0, 1'b1})
      $display("FAIL underflow_err: got %b want %b", {b_err, s_err, b_occ, b_empty}, {1'b1, 1'b1, 7'd0, 1'b1});
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk); ent_req = 1'b1;
    @(negedge clk); ent_req = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++;
    if ({s_occ, s_err, b_err} !== {7'd1, 1'b0, 1'b0})
      $display("FAIL sat_pre: got %b want %b", {s_occ, s_err, b_err}, {7'd1, 1'b0, 1'b0});
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ent_req = 1'b1; ext_req = 1'b1;
    end
    @(negedge clk); ent_req = 1'b0; ext_req = 1'b0;
    repeat (25) @(negedge clk);
    total_cnt++;
    if (s_err !== 1'b1) $display("FAIL sat_small_err: got %b want 1", s_err);
    else pass_cnt++;
    total_cnt++;
    if ({b_err, b_occ} !== {1'b0, 7'd1})
      $display("FAIL sat_big_clean: got %b want %b", {b_err, b_occ}, {1'b0, 7'd1});
    else pass_cnt++;
  endtask

  task automatic test_gate();
`ifdef PARKING_GATE_EN
    int  open_cycles;
    logic closed;
    do_reset();
    @(negedge clk); arrive = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (b_gate !== 1'b1) $display("FAIL gate_open_latency: got %b want 1", b_gate);
    else pass_cnt++;
    open_cycles = 1;
    closed = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!b_gate) begin
        closed = 1'b1;
        break;
      end
      open_cycles++;
    end
    total_cnt++;
    if ({closed, open_cycles} !== {1'b1, 32'sd16})
      $display("FAIL gate_timeout: got closed=%b cycles=%0d want closed=1 cycles=16", closed, open_cycles);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (b_gate !== 1'b1) $display("FAIL gate_reopen: got %b want 1", b_gate);
    else pass_cnt++;
    do_reset();
    @(negedge clk); arrive = 1'b1;
    repeat (5) @(negedge clk);
    ent_req = 1'b1;
    @(negedge clk); ent_req = 1'b0;
    repeat (20) @(negedge clk);
    total_cnt++;
    if (b_gate !== 1'b1) $display("FAIL gate_pass_hold: got %b want 1", b_gate);
    else pass_cnt++;
    arrive = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (b_gate !== 1'b0) $display("FAIL gate_pass_close: got %b want 0", b_gate);
    else pass_cnt++;
`else
    do_reset();
    @(negedge clk); arrive = 1'b1;
    repeat (4) @(negedge clk);
    total_cnt++;
    if ({b_gate, s_gate} !== 2'b00) $display("FAIL gate_disabled: got %b want 00", {b_gate, s_gate});
    else pass_cnt++;
    arrive = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_burst();
    logic inc_seen;
    inc_seen = 1'b0;
    do_reset();
    @(negedge clk); ext_req = 1'b1; arrive = 1'b1;
    @(negedge clk); ext_req = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (b_err !== 1'b1) $display("FAIL midrst_pre_err: got %b want 1", b_err);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ent_req = 1'b1;
    end
    @(negedge clk);
    ent_req = 1'b0; reset_n = 1'b0; arrive = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({b_inc, b_occ, b_err, b_gate, b_empty} !== {1'b0, 7'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL midrst_state: got %b want %b", {b_inc, b_occ, b_err, b_gate, b_empty}, {1'b0, 7'd0, 1'b0, 1'b0, 1'b1});
    else pass_cnt++;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      inc_seen |= b_inc;
    end
    total_cnt++;
    if ({inc_seen, b_occ} !== {1'b0, 7'd0})
      $display("FAIL midrst_no_inc: got %b want %b", {inc_seen, b_occ}, {1'b0, 7'd0});
    else pass_cnt++;
  endtask

  task automatic test_no_overlap();
    total_cnt++;
    if (overlap !== 0) $display("FAIL inc_dec_overlap: got %0d want 0", overlap);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_entry();
    test_back_to_back();
    test_simultaneous();
    test_capacity();
    test_gate_full();
    test_underflow();
    test_saturation();
    test_gate();
    test_reset_mid_burst();
    test_no_overlap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
